uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DBIT, default 8, data bits per frame (matches uart_tx DBIT).
REQ-003 SHALL have parameter GAP_CYC, default 2, idle clk cycles between frames (0 allowed).
REQ-004 SHALL have parameter TIMEOUT, default 65535, max clk cycles waiting for tx_done.
REQ-005 SHALL have port clk  in  1  clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  in  NREQ  per-requester byte pending.
REQ-008 SHALL have port req_data  in  NREQ*DBIT  requester i byte at [i*DBIT +: DBIT].
REQ-009 SHALL have port req_en  in  NREQ  per-requester arbitration enable mask.
REQ-010 SHALL have port req_ack  out  NREQ  one-hot one-cycle pulse, byte of requester i accepted.
REQ-011 SHALL have port tx_start  out  1  one-cycle start pulse to transmitter.
REQ-012 SHALL have port tx_din  out  DBIT  byte to transmitter.
REQ-013 SHALL have port tx_done  in  1  one-cycle frame-complete pulse from transmitter.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port grant_id  out  $clog2(NREQ)  index of requester currently owning transmitter.
REQ-016 SHALL have port timeout_err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-017 SHALL implement FSM IDLE, SEND, WAIT, GAP; all outputs registered.
REQ-018 IDLE: eligible = req_valid & req_en; if nonzero, at next edge go SEND, capture winner data into tx_din, winner index into grant_id.
REQ-019 Winner SHALL be round-robin: first eligible index searching upward (wrapping) from last_grant+1; last_grant resets to NREQ-1 so requester 0 wins first.
REQ-020 SEND lasts exactly one cycle with tx_start=1 and req_ack[grant_id]=1; next state WAIT; last_grant updated to grant_id.
REQ-021 Requester SHALL hold req_valid/req_data until req_ack; arbiter never samples req_data outside IDLE.
REQ-022 tx_din SHALL stay constant from SEND until return to IDLE (transmitter reads it after start).
REQ-023 WAIT: tx_done=1 -> GAP (or IDLE if GAP_CYC=0); gap counter cleared.
REQ-024 WAIT: watchdog counter (width $clog2(TIMEOUT+1)) increments per cycle; at TIMEOUT-1 without tx_done -> IDLE, timeout_err pulse next cycle.
REQ-025 tx_done coinciding with watchdog terminal count SHALL take priority; no timeout_err.
REQ-026 GAP: counts GAP_CYC cycles, then IDLE; requests are not evaluated in GAP.
REQ-027 tx_done while IDLE, SEND or GAP SHALL be ignored.
REQ-028 req_en or req_valid changes after SEND SHALL NOT affect the frame in progress.
REQ-029 Minimum request-to-next-request spacing: IDLE->SEND->WAIT->tx_done->GAP_CYC->IDLE; back-to-back valid from one requester therefore cannot starve others.
REQ-030 Exactly one req_ack bit SHALL be high per frame; req_ack zero in all other cycles.

Reset
REQ-031 On rst_n low: state IDLE, tx_start=0, req_ack=0, tx_din=0, grant_id=0, busy=0, timeout_err=0, counters 0, last_grant=NREQ-1.
REQ-032 Reset mid-frame SHALL abort immediately with no req_ack or timeout_err on release.

Structure
REQ-033 Enum arb_state_e {IDLE, SEND, WAIT, GAP} SHALL reside in the shared states package beside the transmitter state type.
REQ-034 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs eligible mask, last_grant; outputs found, index).

Verification
REQ-035 Reset: assert rst_n=0 mid-WAIT -> all outputs at reset values same cycle; after release no ack/err.
REQ-036 Single request: req_valid=0001, req_data[7:0]=0xA5, en=1111 -> tx_start and req_ack=0001 one cycle, tx_din=0xA5 held until tx_done.
REQ-037 Fairness: all four valid continuously, tx_done 20 cycles after each start -> grant order 0,1,2,3,0, each ack once per round, GAP_CYC=2 idle cycles between frames.
REQ-038 Mask: valid=1111, en=1010 -> only grants 1,3 alternate; en=0000 -> busy stays 0.
REQ-039 Timeout: TIMEOUT=16, never pulse tx_done -> IDLE after 16 WAIT cycles, timeout_err one pulse; tx_done on cycle 16 instead -> GAP, no error.
REQ-040 Stray tx_done in IDLE/GAP -> no state change, no ack.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared FSM encodings for the UART transmit path.
// Transmitter and arbiter state types live side by side here.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    GAP
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin winner search.
// Ports: i_elig mask, i_last_grant in; o_found, o_index out.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_elig,
  input  logic [$clog2(NREQ)-1:0] i_last_grant,
  output logic                    o_found,
  output logic [$clog2(NREQ)-1:0] o_index
);

  localparam int IW = $clog2(NREQ);

  int j;

  // Scan from the farthest offset down so the
  // nearest eligible index above last grant wins.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    j       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(i_last_grant) + k) % NREQ;
      if (i_elig[j]) begin
        o_found = 1'b1;
        o_index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter feeding bytes to one UART transmitter.
// Ports: clk, rst_n; req_valid/req_data/req_en in, req_ack out;
// tx_start/tx_din out, tx_done in; busy, grant_id, timeout_err out.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DBIT-1:0]    req_data,
  input  logic [NREQ-1:0]         req_en,
  output logic [NREQ-1:0]         req_ack,
  output logic                    tx_start,
  output logic [DBIT-1:0]         tx_din,
  input  logic                    tx_done,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    timeout_err
);

  localparam int IW    = $clog2(NREQ);
  localparam int WW    = $clog2(TIMEOUT + 1);
  localparam int GW    = $clog2(GAP_CYC + 2);
  localparam int GLAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GP_LAST = GW'(GLAST);
  localparam logic [IW-1:0] LG_RST  = IW'(NREQ - 1);

  arb_state_e r_state;
  arb_state_e w_nxt_state;

  logic [IW-1:0]   r_last;
  logic [IW-1:0]   w_nxt_last;
  logic [WW-1:0]   r_wd;
  logic [WW-1:0]   w_nxt_wd;
  logic [GW-1:0]   r_gap;
  logic [GW-1:0]   w_nxt_gap;

  logic            r_tx_start;
  logic            w_nxt_start;
  logic [NREQ-1:0] r_req_ack;
  logic [NREQ-1:0] w_nxt_ack;
  logic [DBIT-1:0] r_tx_din;
  logic [DBIT-1:0] w_nxt_din;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   w_nxt_grant;
  logic            r_busy;
  logic            w_nxt_busy;
  logic            r_to_err;
  logic            w_nxt_err;

  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [IW-1:0]   w_idx;

  assign w_elig = req_valid & req_en;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .i_elig      (w_elig),
    .i_last_grant(r_last),
    .o_found     (w_found),
    .o_index     (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last     <= LG_RST;
      r_wd       <= '0;
      r_gap      <= '0;
      r_tx_start <= 1'b0;
      r_req_ack  <= '0;
      r_tx_din   <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_to_err   <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_last     <= w_nxt_last;
      r_wd       <= w_nxt_wd;
      r_gap      <= w_nxt_gap;
      r_tx_start <= w_nxt_start;
      r_req_ack  <= w_nxt_ack;
      r_tx_din   <= w_nxt_din;
      r_grant    <= w_nxt_grant;
      r_busy     <= w_nxt_busy;
      r_to_err   <= w_nxt_err;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_last  = r_last;
    w_nxt_wd    = r_wd;
    w_nxt_gap   = r_gap;
    w_nxt_start = 1'b0;
    w_nxt_ack   = '0;
    w_nxt_din   = r_tx_din;
    w_nxt_grant = r_grant;
    w_nxt_err   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Start pulse and ack are set up here so
        // they are registered during the SEND cycle.
        if (w_found) begin
          w_nxt_state = SEND;
          w_nxt_din   = req_data[int'(w_idx)*DBIT +: DBIT];
          w_nxt_grant = w_idx;
          w_nxt_start = 1'b1;
          w_nxt_ack   = {{(NREQ-1){1'b0}}, 1'b1} << w_idx;
        end
      end
      SEND: begin
        w_nxt_state = WAIT;
        w_nxt_last  = r_grant;
        w_nxt_wd    = '0;
      end
      WAIT: begin
        // tx_done beats the watchdog on the terminal cycle.
        if (tx_done) begin
          w_nxt_gap   = '0;
          w_nxt_state = (GAP_CYC == 0) ? IDLE : GAP;
        end else if (r_wd == WD_LAST) begin
          w_nxt_state = IDLE;
          w_nxt_err   = 1'b1;
        end else begin
          w_nxt_wd = r_wd + 1'b1;
        end
      end
      GAP: begin
        if (r_gap == GP_LAST) begin
          w_nxt_state = IDLE;
        end else begin
          w_nxt_gap = r_gap + 1'b1;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
    w_nxt_busy = (w_nxt_state != IDLE);
  end

  assign req_ack     = r_req_ack;
  assign tx_start    = r_tx_start;
  assign tx_din      = r_tx_din;
  assign busy        = r_busy;
  assign grant_id    = r_grant;
  assign timeout_err = r_to_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for the UART transmit arbiter.
// Main instance uses defaults; a second one has a short watchdog.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_en;
  logic [3:0]  req_ack;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  logic [3:0]  wv;
  logic [3:0]  wd_ack;
  logic        wd_start;
  logic [7:0]  wd_din;
  logic        wdone;
  logic        wd_busy;
  logic [1:0]  wd_grant;
  logic        wd_err;

  always #5 clk = ~clk;

  uart_tx_arb u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_en     (req_en),
    .req_ack    (req_ack),
    .tx_start   (tx_start),
    .tx_din     (tx_din),
    .tx_done    (tx_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
  );

  uart_tx_arb #(
    .NREQ(4), .DBIT(8), .GAP_CYC(2), .TIMEOUT(16)
  ) u_wd (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (wv),
    .req_data   (req_data),
    .req_en     (req_en),
    .req_ack    (wd_ack),
    .tx_start   (wd_start),
    .tx_din     (wd_din),
    .tx_done    (wdone),
    .busy       (wd_busy),
    .grant_id   (wd_grant),
    .timeout_err(wd_err)
  );

  typedef struct {
    int         id;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ph = 0;
  int   exp_sp = 0;
  int   ack_cnt[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mon();
    int   prev_c;
    int   prev_ph;
    exp_t e;
    prev_c  = -1;
    prev_ph = -1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexp_start: got grant %0d want none",
                   grant_id);
        end else begin
          e = sb.pop_front();
          chk("grant", int'(grant_id), e.id);
          chk("din", int'(tx_din), int'(e.d));
          chk("ack", int'(req_ack), 1 << e.id);
          if (exp_sp > 0 && ph == prev_ph)
            chk("spacing", cyc - prev_c, exp_sp);
          prev_c  = cyc;
          prev_ph = ph;
        end
        for (int i = 0; i < 4; i++)
          if (req_ack[i]) ack_cnt[i]++;
      end else if (rst_n && req_ack != 4'b0) begin
        n_chk++;
        n_err++;
        $display("FAIL stray_ack: got %b want 0000", req_ack);
      end
    end
  endtask

  task automatic wait_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 200);
    if (!tx_start) begin
      n_chk++;
      n_err++;
      $display("FAIL start_timeout: got no start want one");
    end
  endtask

  task automatic wait_wd_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wd_start && n < 200);
    chk("wd_start_seen", int'(wd_start), 1);
  endtask

  task automatic pulse_done(input int lat);
    repeat (lat) @(posedge clk);
    #1 tx_done = 1'b1;
    @(posedge clk);
    #1 tx_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic stim();
    int bad;
    rst_n     = 1'b0;
    req_valid = 4'b0;
    req_en    = 4'hF;
    wv        = 4'b0;
    tx_done   = 1'b0;
    wdone     = 1'b0;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    #2;
    chk("rst_start", int'(tx_start), 0);
    chk("rst_ack", int'(req_ack), 0);
    chk("rst_din", int'(tx_din), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(timeout_err), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // fairness: all four pending, 20-cycle frames
    ph     = 1;
    exp_sp = 24;
    push(0, 8'h10);
    push(1, 8'h11);
    push(2, 8'h12);
    push(3, 8'h13);
    push(0, 8'h10);
    @(posedge clk);
    #1 req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_start();
      if (k == 4) req_valid = 4'b0;
      pulse_done(20);
    end
    wait_idle();
    exp_sp = 0;
    chk("fair_cnt0", ack_cnt[0], 2);
    chk("fair_cnt1", ack_cnt[1], 1);
    chk("fair_cnt2", ack_cnt[2], 1);
    chk("fair_cnt3", ack_cnt[3], 1);

    // single request
    ph = 0;
    @(posedge clk);
    #1 req_data[7:0] = 8'hA5;
    push(0, 8'hA5);
    req_valid = 4'b0001;
    wait_start();
    req_valid = 4'b0;
    req_data[7:0] = 8'h10;
    pulse_done(20);
    chk("din_held", int'(tx_din), 8'hA5);
    chk("gap_busy", int'(busy), 1);
    wait_idle();
    chk("single_cnt0", ack_cnt[0], 3);

    // mask 1010 alternates 1,3
    ph     = 2;
    exp_sp = 9;
    push(1, 8'h11);
    push(3, 8'h13);
    push(1, 8'h11);
    push(3, 8'h13);
    @(posedge clk);
    #1 req_en = 4'b1010;
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_start();
      if (k == 3) req_valid = 4'b0;
      pulse_done(5);
    end
    wait_idle();
    exp_sp = 0;
    ph     = 0;
    chk("mask_cnt1", ack_cnt[1], 3);
    chk("mask_cnt3", ack_cnt[3], 3);

    // all masked, plus a stray tx_done while idle
    @(posedge clk);
    #1 req_en = 4'b0;
    req_valid = 4'hF;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1 tx_done = (k == 10);
      @(negedge clk);
      if (busy) bad++;
    end
    tx_done = 1'b0;
    chk("masked_busy", bad, 0);
    req_valid = 4'b0;
    req_en    = 4'hF;

    // stray tx_done in GAP must not stretch the gap
    @(posedge clk);
    push(2, 8'h12);
    #1 req_valid = 4'b0100;
    wait_start();
    req_valid = 4'b0;
    pulse_done(5);
    tx_done = 1'b1;
    @(posedge clk);
    #1 tx_done = 1'b0;
    chk("gap2_busy", int'(busy), 1);
    @(posedge clk);
    #1 chk("gap_end_idle", int'(busy), 0);

    // watchdog expiry, TIMEOUT=16
    @(posedge clk);
    #1 wv = 4'b0001;
    wait_wd_start();
    chk("wd_grant", int'(wd_grant), 0);
    chk("wd_din", int'(wd_din), 8'h10);
    chk("wd_ack", int'(wd_ack), 1);
    wv  = 4'b0;
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (!wd_busy || wd_err) bad++;
    end
    chk("wd_wait_len", bad, 0);
    @(negedge clk);
    chk("wd_to_idle", int'(wd_busy), 0);
    chk("wd_err_pulse", int'(wd_err), 1);
    @(negedge clk);
    chk("wd_err_once", int'(wd_err), 0);

    // tx_done on the terminal watchdog cycle wins
    @(posedge clk);
    #1 wv = 4'b0001;
    wait_wd_start();
    wv = 4'b0;
    repeat (16) @(posedge clk);
    #1 wdone = 1'b1;
    @(posedge clk);
    #1 wdone = 1'b0;
    @(negedge clk);
    chk("wd_gap1_busy", int'(wd_busy), 1);
    chk("wd_no_err", int'(wd_err), 0);
    @(negedge clk);
    chk("wd_gap2_busy", int'(wd_busy), 1);
    @(negedge clk);
    chk("wd_gap_idle", int'(wd_busy), 0);
    chk("wd_no_err2", int'(wd_err), 0);

    // reset asserted mid-WAIT
    @(posedge clk);
    push(1, 8'h11);
    #1 req_valid = 4'b0010;
    wait_start();
    req_valid = 4'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_start", int'(tx_start), 0);
    chk("mid_rst_ack", int'(req_ack), 0);
    chk("mid_rst_din", int'(tx_din), 0);
    chk("mid_rst_grant", int'(grant_id), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_err", int'(timeout_err), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_start || busy || timeout_err || req_ack != 4'b0)
        bad++;
    end
    chk("post_rst_quiet", bad, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    fork
      mon();
      begin
        stim();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
      end
      begin
        #2000000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1);
      end
    join_any
  end

endmodule
